// File: rtl/snd_cmd_pkg.sv
`default_nettype none
//==============================================================================
// Module   : snd_cmd_pkg
// Desc     : Shared types and constants for the sound-command transmitter.
// Revision : 1.0 - initial release
//==============================================================================
package snd_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP    = 3'd1,
    S_STROBE   = 3'd2,
    S_HOLD     = 3'd3,
    S_WAIT_ACK = 3'd4
  } snd_state_t;

  typedef enum logic {
    KIND_CMD = 1'b0,
    KIND_NMI = 1'b1
  } snd_kind_t;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_TMO   = 3;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/snd_cmd_fifo.sv
`default_nettype none
//==============================================================================
// Module   : snd_cmd_fifo
// Desc     : Synchronous byte FIFO; a push into a full FIFO is accepted only
//            when a pop happens in the same cycle.
// Revision : 1.0 - initial release
//==============================================================================
module snd_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;

  logic [7:0]      r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic            w_push;
  logic            w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == c_CW'(DEPTH));
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign dout   = r_mem[r_rd_ptr];
  assign count  = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/sound_cmd_tx.sv
`default_nettype none
//==============================================================================
// Module   : sound_cmd_tx
// Desc     : Queues main-CPU sound commands and strobes them to the sound board
//            with an ack handshake on DB3; also forwards NMI-gate writes.
//            Optional: define SND_CMD_TIMEOUT_EN for a WAIT_ACK timeout.
// Revision : 1.0 - initial release
//==============================================================================
module sound_cmd_tx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SETUP_W     = 2,
  parameter int STROBE_W    = 3,
  parameter int HOLD_W      = 2,
  parameter int ACK_TIMEOUT = 48000
) (
  input  logic       clkm_48MHZ,
  input  logic       SND_RST,
  input  logic       cmd_wr,
  input  logic [7:0] cmd_data,
  input  logic       nmi_wr,
  input  logic       nmi_data,
  input  logic       stat_clr,
  input  logic       DB3_in,
  output logic [7:0] CPU_DIN,
  output logic       EPORT1,
  output logic       EPORT2,
  output logic [7:0] status
);

  import snd_cmd_pkg::*;

`ifdef SND_CMD_TIMEOUT_EN
  localparam int c_PH_MAX = max_of4(SETUP_W, STROBE_W, HOLD_W, ACK_TIMEOUT);
`else
  localparam int c_PH_MAX = max_of4(SETUP_W, STROBE_W, HOLD_W, 2);
`endif
  localparam int c_PH_W  = $clog2(c_PH_MAX + 1);
  localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [c_PH_W-1:0] c_SETUP_LAST  = c_PH_W'(SETUP_W - 1);
  localparam logic [c_PH_W-1:0] c_STROBE_LAST = c_PH_W'(STROBE_W - 1);
  localparam logic [c_PH_W-1:0] c_HOLD_LAST   = c_PH_W'(HOLD_W - 1);

  snd_state_t          r_state;
  snd_kind_t           r_kind;
  logic [c_PH_W-1:0]   r_phase;
  logic                r_nmi_pend;
  logic                r_nmi_val;
  logic                r_ovf;
  logic                w_tmo_bit;
  logic                w_pop;
  logic                w_ack;
  logic                w_ovf_evt;
  logic [7:0]          w_fifo_dout;
  logic [c_CNT_W-1:0]  w_count;
  logic                w_fifo_empty;
  logic                w_fifo_full;

  snd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clkm_48MHZ),
    .rst   (SND_RST),
    .push  (cmd_wr),
    .pop   (w_pop),
    .din   (cmd_data),
    .dout  (w_fifo_dout),
    .count (w_count),
    .empty (w_fifo_empty),
    .full  (w_fifo_full)
  );

  // NMI requests outrank queued commands
  assign w_pop     = (r_state == S_IDLE) && !r_nmi_pend && !w_fifo_empty;
  assign w_ovf_evt = cmd_wr && w_fifo_full && !w_pop;
  // The first WAIT_ACK cycle ignores DB3 while the board latch settles
  assign w_ack     = (r_state == S_WAIT_ACK) && (r_phase != '0) && !DB3_in;

`ifdef SND_CMD_TIMEOUT_EN
  localparam logic [c_PH_W-1:0] c_TMO_LAST = c_PH_W'(ACK_TIMEOUT - 1);

  logic r_tmo;
  logic w_tmo_evt;

  assign w_tmo_evt = (r_state == S_WAIT_ACK) && !w_ack && (r_phase == c_TMO_LAST);
  assign w_tmo_bit = r_tmo;

  always_ff @(posedge clkm_48MHZ) begin
    if (SND_RST)        r_tmo <= 1'b0;
    else if (w_tmo_evt) r_tmo <= 1'b1;
    else if (stat_clr)  r_tmo <= 1'b0;
  end
`else
  // No timeout hardware; ACK_TIMEOUT is referenced only to keep it in the interface
  assign w_tmo_bit = (ACK_TIMEOUT < 0);
`endif

  always_ff @(posedge clkm_48MHZ) begin
    if (SND_RST) begin
      r_state <= S_IDLE;
      r_kind  <= KIND_CMD;
      r_phase <= '0;
      CPU_DIN <= 8'h00;
      EPORT1  <= 1'b0;
      EPORT2  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_phase <= '0;
          if (r_nmi_pend) begin
            CPU_DIN <= {7'b0, r_nmi_val};
            r_kind  <= KIND_NMI;
            r_state <= S_SETUP;
          end else if (!w_fifo_empty) begin
            CPU_DIN <= w_fifo_dout;
            r_kind  <= KIND_CMD;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_phase == c_SETUP_LAST) begin
            r_phase <= '0;
            r_state <= S_STROBE;
            EPORT1  <= (r_kind == KIND_CMD);
            EPORT2  <= (r_kind == KIND_NMI);
          end else begin
            r_phase <= r_phase + c_PH_W'(1);
          end
        end
        S_STROBE: begin
          if (r_phase == c_STROBE_LAST) begin
            r_phase <= '0;
            r_state <= S_HOLD;
            EPORT1  <= 1'b0;
            EPORT2  <= 1'b0;
          end else begin
            r_phase <= r_phase + c_PH_W'(1);
          end
        end
        S_HOLD: begin
          if (r_phase == c_HOLD_LAST) begin
            r_phase <= '0;
            r_state <= (r_kind == KIND_CMD) ? S_WAIT_ACK : S_IDLE;
          end else begin
            r_phase <= r_phase + c_PH_W'(1);
          end
        end
        S_WAIT_ACK: begin
          if (w_ack) begin
            r_phase <= '0;
            r_state <= S_IDLE;
          end
`ifdef SND_CMD_TIMEOUT_EN
          else if (w_tmo_evt) begin
            r_phase <= '0;
            r_state <= S_IDLE;
          end else begin
            r_phase <= r_phase + c_PH_W'(1);
          end
`else
          else if (r_phase == '0) begin
            r_phase <= c_PH_W'(1);
          end
`endif
        end
        default: begin
          r_phase <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // A write before service overwrites the pending value
  always_ff @(posedge clkm_48MHZ) begin
    if (SND_RST) begin
      r_nmi_pend <= 1'b0;
      r_nmi_val  <= 1'b0;
    end else if (nmi_wr) begin
      r_nmi_pend <= 1'b1;
      r_nmi_val  <= nmi_data;
    end else if (r_state == S_IDLE) begin
      r_nmi_pend <= 1'b0;
    end
  end

  always_ff @(posedge clkm_48MHZ) begin
    if (SND_RST)        r_ovf <= 1'b0;
    else if (w_ovf_evt) r_ovf <= 1'b1;
    else if (stat_clr)  r_ovf <= 1'b0;
  end

  always_comb begin
    status           = 8'h00;
    status[ST_EMPTY] = (w_count == '0);
    status[ST_FULL]  = (w_count == c_CNT_W'(FIFO_DEPTH));
    status[ST_OVF]   = r_ovf;
    status[ST_TMO]   = w_tmo_bit;
  end

endmodule
`default_nettype wire

// File: tb/tb_sound_cmd_tx.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module   : tb_sound_cmd_tx
// Desc     : Self-checking bench for sound_cmd_tx (directed table, corner
//            sequences and random traffic against a transaction-level model).
// Revision : 1.0 - initial release
//==============================================================================
module tb_sound_cmd_tx;

  localparam int DEPTH   = 4;
  localparam int SETUP   = 2;
  localparam int STRB    = 3;
  localparam int HOLD    = 2;
  localparam int TMO     = 48000;
  localparam int MIN_GAP = SETUP + STRB + HOLD + 2 + 1;

  logic       clkm_48MHZ = 1'b0;
  logic       SND_RST    = 1'b1;
  logic       cmd_wr     = 1'b0;
  logic [7:0] cmd_data   = 8'h00;
  logic       nmi_wr     = 1'b0;
  logic       nmi_data   = 1'b0;
  logic       stat_clr   = 1'b0;
  logic       DB3_in     = 1'b0;
  logic [7:0] CPU_DIN;
  logic       EPORT1;
  logic       EPORT2;
  logic [7:0] status;

  sound_cmd_tx #(
    .FIFO_DEPTH (DEPTH),
    .SETUP_W    (SETUP),
    .STROBE_W   (STRB),
    .HOLD_W     (HOLD),
    .ACK_TIMEOUT(TMO)
  ) dut (
    .clkm_48MHZ (clkm_48MHZ),
    .SND_RST    (SND_RST),
    .cmd_wr     (cmd_wr),
    .cmd_data   (cmd_data),
    .nmi_wr     (nmi_wr),
    .nmi_data   (nmi_data),
    .stat_clr   (stat_clr),
    .DB3_in     (DB3_in),
    .CPU_DIN    (CPU_DIN),
    .EPORT1     (EPORT1),
    .EPORT2     (EPORT2),
    .status     (status)
  );

  always #5 clkm_48MHZ = ~clkm_48MHZ;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Transaction model: expected strobes in order, per port
  logic [7:0] cmdq[$];
  logic       nmiq[$];
  bit         kind_log[$];
  int         outstanding = 0;
  bit         nmi_out     = 1'b0;
  bit         rand_db3    = 1'b0;
  int         db3_cnt     = 0;
  int         n_rise      = 0;

  bit         p1 = 1'b0, p2 = 1'b0;
  int         w1 = 0, w2 = 0;
  logic [7:0] held = 8'h00;
  int         hold_left = 0;
  logic [7:0] d1 = 8'h00, d2 = 8'h00;
  int         last_rise = 0;
  bit         last_valid = 1'b0;

  typedef struct {
    logic       cw;
    logic [7:0] cd;
    logic       sc;
    logic [7:0] est;
    logic [7:0] edin;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_true(input string name, input bit ok, input int act, input int req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic mon_port(input bit now, input bit prev, input bit is_nmi, inout int w);
    logic [7:0] expv;
    string nm;
    nm = is_nmi ? "eport2" : "eport1";
    if (now && !prev) begin
      chk({nm, "_overlap"}, {31'b0, EPORT1 & EPORT2}, 32'd0);
      if (is_nmi ? (nmiq.size() == 0) : (cmdq.size() == 0)) begin
        chk_true({nm, "_unexpected"}, 1'b0, 1, 0);
        held = CPU_DIN;
      end else begin
        if (is_nmi) begin
          expv    = {7'b0, nmiq.pop_front()};
          nmi_out = 1'b0;
        end else begin
          expv = cmdq.pop_front();
          if (outstanding > 0) outstanding--;
          if (last_valid)
            chk_true("cmd_spacing", (cyc - last_rise) >= MIN_GAP, cyc - last_rise, MIN_GAP);
          last_rise  = cyc;
          last_valid = 1'b1;
        end
        chk({nm, "_data"}, CPU_DIN, expv);
        chk({nm, "_setup"}, d2, expv);
        held = expv;
      end
      kind_log.push_back(is_nmi);
      n_rise++;
      w = 1;
    end else if (now) begin
      w++;
      chk({nm, "_stable"}, CPU_DIN, held);
    end else if (prev) begin
      chk({nm, "_width"}, w, STRB);
      hold_left = HOLD;
    end
  endtask

  // One clock: sample #1 after the edge, run the monitor and the board model
  task automatic step();
    @(posedge clkm_48MHZ);
    #1;
    cyc++;
    if (SND_RST) begin
      cmdq.delete();
      nmiq.delete();
      outstanding = 0;
      nmi_out     = 1'b0;
      p1 = 1'b0; p2 = 1'b0; w1 = 0; w2 = 0;
      hold_left  = 0;
      last_valid = 1'b0;
      d1 = CPU_DIN; d2 = CPU_DIN;
      db3_cnt = 0;
      return;
    end
    mon_port(EPORT1, p1, 1'b0, w1);
    mon_port(EPORT2, p2, 1'b1, w2);
    if (hold_left > 0 && !EPORT1 && !EPORT2) begin
      chk("hold_data", CPU_DIN, held);
      hold_left--;
    end
    if (rand_db3) begin
      if (EPORT1) begin
        DB3_in  = 1'b1;
        db3_cnt = $urandom_range(0, 25);
      end else if (db3_cnt > 0) begin
        db3_cnt--;
      end else begin
        DB3_in = 1'b0;
      end
    end
    d2 = d1;
    d1 = CPU_DIN;
    p1 = EPORT1;
    p2 = EPORT2;
  endtask

  task automatic do_reset();
    cmd_wr = 1'b0; nmi_wr = 1'b0; stat_clr = 1'b0;
    rand_db3 = 1'b0; DB3_in = 1'b0;
    SND_RST = 1'b1;
    step();
    chk("rst_status", status, 8'h01);
    chk("rst_din", CPU_DIN, 8'h00);
    chk("rst_ep", {EPORT1, EPORT2}, 2'b00);
    SND_RST = 1'b0;
    kind_log.delete();
  endtask

  task automatic push_cmd(input logic [7:0] d);
    cmd_wr = 1'b1; cmd_data = d;
    cmdq.push_back(d);
    outstanding++;
    step();
    cmd_wr = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((cmdq.size() != 0 || nmiq.size() != 0) && n < budget) begin
      step();
      n++;
    end
    repeat (MIN_GAP + 4) step();
    chk_true("drain", cmdq.size() == 0 && nmiq.size() == 0, cmdq.size() + nmiq.size(), 0);
  endtask

  initial begin
    int n;
    int n0;

    tbl[0] = '{1'b1, 8'h10, 1'b0, 8'h00, 8'h00};
    tbl[1] = '{1'b1, 8'h11, 1'b0, 8'h00, 8'h10};
    tbl[2] = '{1'b1, 8'h12, 1'b0, 8'h00, 8'h10};
    tbl[3] = '{1'b1, 8'h13, 1'b0, 8'h00, 8'h10};
    tbl[4] = '{1'b1, 8'h14, 1'b0, 8'h02, 8'h10};
    tbl[5] = '{1'b1, 8'h15, 1'b0, 8'h06, 8'h10};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 8'h06, 8'h10};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 8'h02, 8'h10};
    tbl[8] = '{1'b1, 8'h16, 1'b1, 8'h06, 8'h10};
    tbl[9] = '{1'b0, 8'h00, 1'b1, 8'h02, 8'h10};

    // Single command with immediate ack: timing of CPU_DIN and EPORT1
    do_reset();
    push_cmd(8'hA5);
    chk("a5_din_pre", CPU_DIN, 8'h00);
    chk("a5_status_pre", status, 8'h00);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("a5_eport1", {31'b0, EPORT1}, (k >= 3 && k <= 5) ? 32'd1 : 32'd0);
      if (k == 1) chk("a5_din", CPU_DIN, 8'hA5);
    end
    repeat (4) step();
    chk("a5_status_end", status, 8'h01);

    // Fill / overflow / sticky clear table with DB3 held high
    do_reset();
    DB3_in = 1'b1;
    cmdq.push_back(8'h10);
    for (int i = 0; i < 10; i++) begin
      cmd_wr = tbl[i].cw; cmd_data = tbl[i].cd; stat_clr = tbl[i].sc;
      step();
      cmd_wr = 1'b0; stat_clr = 1'b0;
      chk($sformatf("tbl%0d_status", i), status, tbl[i].est);
      chk($sformatf("tbl%0d_din", i), CPU_DIN, tbl[i].edin);
    end
    repeat (8) step();

    // NMI priority over a queued command, last NMI write wins
    do_reset();
    DB3_in = 1'b1;
    push_cmd(8'h31);
    push_cmd(8'h32);
    nmi_wr = 1'b1; nmi_data = 1'b0; step();
    nmi_wr = 1'b1; nmi_data = 1'b1; step();
    nmi_wr = 1'b0;
    nmiq.push_back(1'b1);
    repeat (20) step();
    DB3_in = 1'b0;
    wait_drain(100);
    chk("nmi_order_len", kind_log.size(), 3);
    if (kind_log.size() == 3)
      chk("nmi_order", {kind_log[0], kind_log[1], kind_log[2]}, 3'b010);
    chk("nmi_status_end", status, 8'h01);

    // Push while full in the same cycle as the IDLE pop
    do_reset();
    DB3_in = 1'b1;
    for (int i = 0; i < 5; i++) push_cmd(8'h40 + 8'(i));
    repeat (15) step();
    chk("fullpop_pre", status, 8'h02);
    DB3_in = 1'b0;
    step();
    push_cmd(8'h45);
    chk("fullpop_status", status, 8'h02);
    chk("fullpop_din", CPU_DIN, 8'h41);
    wait_drain(200);
    chk("fullpop_end", status, 8'h01);

    // Reset during the strobe phase
    do_reset();
    push_cmd(8'h77);
    n = 0;
    while (!EPORT1 && n < 20) begin step(); n++; end
    chk_true("rst_mid_reach", EPORT1 == 1'b1, n, 20);
    SND_RST = 1'b1;
    step();
    chk("rst_mid_ep1", {31'b0, EPORT1}, 32'd0);
    chk("rst_mid_status", status, 8'h01);
    SND_RST = 1'b0;
    n0 = n_rise;
    repeat (30) step();
    chk("rst_mid_no_strobe", n_rise - n0, 0);

    // Random traffic with a responsive board model
    do_reset();
    rand_db3 = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      cmd_wr = (outstanding < DEPTH) && ($urandom_range(0, 3) == 0);
      if (cmd_wr) begin
        cmd_data = 8'($urandom);
        cmdq.push_back(cmd_data);
        outstanding++;
      end
      nmi_wr = !nmi_out && ($urandom_range(0, 24) == 0);
      if (nmi_wr) begin
        nmi_data = 1'($urandom);
        nmiq.push_back(nmi_data);
        nmi_out = 1'b1;
      end
      stat_clr = ($urandom_range(0, 49) == 0);
      step();
      cmd_wr = 1'b0; nmi_wr = 1'b0; stat_clr = 1'b0;
      if (i % 50 == 0) chk("rand_sticky", {30'b0, status[3:2]}, 32'd0);
    end
    wait_drain(400);
    chk("rand_status_end", status, 8'h01);

`ifdef SND_CMD_TIMEOUT_EN
    // Stuck ack: timeout after TMO WAIT_ACK cycles, next byte proceeds
    do_reset();
    DB3_in = 1'b1;
    push_cmd(8'h60);
    push_cmd(8'h61);
    n = 0;
    while (!EPORT1 && n < 40) begin step(); n++; end
    while (EPORT1 && n < 40) begin step(); n++; end
    chk_true("tmo_first_strobe", n < 40, n, 40);
    n = 0;
    while (!status[3] && n < TMO + 100) begin step(); n++; end
    chk("tmo_latency", n, TMO + 2);
    chk("tmo_bit", {31'b0, status[3]}, 32'd1);
    wait_drain(100);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("tmo_clear", status, 8'h01);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sound_cmd_tx.md
Name: sound_cmd_tx

Overview:
Main-CPU-side transmitter for the sound-command mailbox. It queues command bytes written by the main CPU and presents each one on the sound data bus, CPU_DIN, with an EPORT1 strobe. After each strobe it waits for the sound board's pending flag (DB3) to clear before sending the next byte. It also forwards NMI-gate writes on EPORT2 and exposes a status byte to the main CPU. It sits in the top level between the main CPU write decode and game_sound.

Parameters:
FIFO_DEPTH, 4, command queue depth; power of 2, minimum 2.
SETUP_W, 2, cycles CPU_DIN is held stable before the strobe rises.
STROBE_W, 3, cycles EPORT1/EPORT2 stay high.
HOLD_W, 2, cycles CPU_DIN is held after the strobe falls.
ACK_TIMEOUT, 48000, WAIT_ACK cycle limit (1 ms at 48 MHz); used only with the timeout feature.

Ports:
clkm_48MHZ  in  1  master clock; all logic on the rising edge.
SND_RST  in  1  synchronous, active-high reset.
cmd_wr  in  1  one-cycle strobe: main CPU writes a sound command.
cmd_data  in  8  command byte, valid with cmd_wr.
nmi_wr  in  1  one-cycle strobe: main CPU writes the NMI gate.
nmi_data  in  1  NMI gate value, valid with nmi_wr.
stat_clr  in  1  one-cycle strobe: clears the sticky status bits.
DB3_in  in  1  sound board pending flag, already in the clkm_48MHZ domain; 1 = latched byte not yet read.
CPU_DIN  out  8  data presented to the sound board.
EPORT1  out  1  command latch strobe.
EPORT2  out  1  NMI gate latch strobe.
status  out  8  {4'b0, timeout, overflow, full, empty}.

Behaviour:
- Reset (cycle after SND_RST sampled high): CPU_DIN=0, EPORT1=0, EPORT2=0, FIFO empty, sticky bits 0, NMI request cleared, FSM=IDLE, so status=8'h01.
- Reset mid-transfer: the strobe drops in the same cycle reset is sampled. The in-flight byte is lost and no partial strobe resumes.
- FIFO push on cmd_wr:
  - accepted when not full, or when full with a pop in the same cycle;
  - otherwise the byte is dropped and overflow is set.
- FIFO pop occurs on the IDLE->SETUP transition. Count width is $clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- NMI request:
  - nmi_wr latches nmi_data and sets a pending request;
  - a second nmi_wr before service overwrites the value (last write wins).
- FSM states: IDLE, SETUP, STROBE, HOLD, WAIT_ACK.
- IDLE:
  - NMI request pending: CPU_DIN={7'b0,nmi_data}, go to SETUP with kind=NMI; the NMI request has priority over the FIFO.
  - Otherwise FIFO not empty: pop, CPU_DIN=byte, go to SETUP with kind=CMD.
- SETUP: hold for SETUP_W cycles, then go to STROBE.
- STROBE: EPORT1 (kind=CMD) or EPORT2 (kind=NMI) is high for exactly STROBE_W cycles, then go to HOLD.
- HOLD: strobes low for HOLD_W cycles. Then kind=CMD goes to WAIT_ACK; kind=NMI goes to IDLE.
- WAIT_ACK: go to IDLE on the first cycle DB3_in==0, but no earlier than 2 cycles after entry (this masks latch propagation).
- CPU_DIN holds its last value in IDLE and WAIT_ACK.
- Minimum command-to-command spacing: SETUP_W+STROBE_W+HOLD_W+2+1 cycles.
- Status bits:
  - empty and full reflect the registered FIFO count;
  - overflow and timeout are sticky;
  - stat_clr clears them, but a set event in the same cycle wins.

Optional Feature:
SND_CMD_TIMEOUT_EN.
- Defined: WAIT_ACK has a counter. At ACK_TIMEOUT cycles without an ack, the FSM sets timeout and returns to IDLE, and the next byte proceeds.
- Undefined: WAIT_ACK waits indefinitely, the timeout bit is tied to 0, and no counter is synthesised.

Decomposition:
- Package snd_cmd_pkg holds:
  - FSM state enum;
  - kind enum (CMD/NMI);
  - status bit index constants ST_EMPTY=0, ST_FULL=1, ST_OVF=2, ST_TMO=3.
- Sub-module snd_cmd_fifo: synchronous FIFO, parameter DEPTH, with push, pop, din, dout, count, empty and full.
- The top module holds the FSM, the shared phase counter and the status logic.

Test Plan:
- Reset, then cmd_wr with 8'hA5 and DB3_in held low → CPU_DIN=8'hA5 appears 1 cycle later. EPORT1 rises 2 cycles after that, stays high 3 cycles, then falls. status returns to 8'h01.
- Four cmd_wr with DB3_in held high → one byte in flight and three queued. A fifth and sixth cmd_wr → overflow bit set, status=8'h06 (full+overflow). stat_clr → 8'h02.
- nmi_wr with data 1 issued while a command waits in the FIFO → EPORT2 strobe with CPU_DIN=8'h01 precedes EPORT1 for the queued byte. EPORT1 never pulses during an NMI transfer.
- SND_CMD_TIMEOUT_EN defined, DB3_in stuck high → after 48000 WAIT_ACK cycles, status bit3=1 and the next queued byte is strobed.
- SND_RST asserted during the STROBE phase → EPORT1=0 the cycle after, status=8'h01, no further strobe.
- cmd_wr while full in the same cycle as the IDLE pop → byte accepted, overflow stays 0, count unchanged.
